// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter and access sequencer that shares one
// single-ported Memory between a fetch requester (F) and a data requester (D).
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   f_req/f_addr          fetch request (read only), held until f_ack
//   f_ack/f_rdata         one-cycle done pulse, fetch read data
//   d_req/d_rw/d_addr     data request (rw: 1=read, 0=write), held until d_ack
//   d_wdata               write data
//   d_ack/d_rdata         one-cycle done pulse, data read data
//   err                   pulses with the ack when the access timed out
//   mem_enable/mem_rw     Memory Enable / RW
//   mem_addr/mem_wdata    Memory Address / Data_in
//   mem_rdata/mem_mfc     Memory Data_out / MFC (asynchronous)
module mem_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_rw,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          err,
  output logic          mem_enable,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_mfc
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_MFC,
    RELEASE,
    DONE
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic          mfc_q;
  logic          mfc_s;
  logic [CW-1:0] cnt;
  logic          cnt_end;
  logic          last_d;
  logic          gnt_d;
  logic          tmo;
  logic          win_d;

  assign cnt_end = (cnt == CW'(TIMEOUT - 1));

  // D wins when alone, or on a tie when F was the last tie winner.
  assign win_d = d_req && (!f_req || !last_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mfc_q <= 1'b0;
      mfc_s <= 1'b0;
    end else begin
      mfc_q <= mem_mfc;
      mfc_s <= mfc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_d     <= 1'b1;
      gnt_d      <= 1'b0;
      tmo        <= 1'b0;
      cnt        <= '0;
      f_ack      <= 1'b0;
      d_ack      <= 1'b0;
      err        <= 1'b0;
      f_rdata    <= '0;
      d_rdata    <= '0;
      mem_enable <= 1'b0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      f_ack <= 1'b0;
      d_ack <= 1'b0;
      err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (f_req || d_req) begin
            gnt_d <= win_d;
            // Round-robin pointer moves on ties only.
            if (f_req && d_req) begin
              last_d <= win_d;
            end
            mem_rw    <= win_d ? d_rw : 1'b1;
            mem_addr  <= win_d ? d_addr : f_addr;
            mem_wdata <= win_d ? d_wdata : '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_enable <= 1'b1;
          cnt        <= '0;
          state      <= WAIT_MFC;
        end
        WAIT_MFC: begin
          if (mfc_s) begin
            if (mem_rw) begin
              if (gnt_d) begin
                d_rdata <= mem_rdata;
              end else begin
                f_rdata <= mem_rdata;
              end
            end
            mem_enable <= 1'b0;
            cnt        <= '0;
            state      <= RELEASE;
          end else if (cnt_end) begin
            mem_enable <= 1'b0;
            tmo        <= 1'b1;
            cnt        <= '0;
            state      <= RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (!mfc_s || cnt_end) begin
            f_ack <= !gnt_d;
            d_ack <= gnt_d;
            // Leaving with mfc_s still high means the release timed out.
            err   <= tmo | mfc_s;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          tmo   <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter
// against a behavioural Memory device and a reference model.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          f_req = 1'b0;
  logic [AW-1:0] f_addr = '0;
  logic          f_ack;
  logic [DW-1:0] f_rdata;
  logic          d_req = 1'b0;
  logic          d_rw = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          err;
  logic          mem_enable;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_mfc = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .AW(AW),
    .DW(DW),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .f_req(f_req),
    .f_addr(f_addr),
    .f_ack(f_ack),
    .f_rdata(f_rdata),
    .d_req(d_req),
    .d_rw(d_rw),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_ack(d_ack),
    .d_rdata(d_rdata),
    .err(err),
    .mem_enable(mem_enable),
    .mem_rw(mem_rw),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_mfc(mem_mfc)
  );

  int passed = 0;
  int total = 0;
  int fails = 0;

  bit [DW-1:0] dev [bit [AW-1:0]];
  bit [DW-1:0] ref_mem [bit [AW-1:0]];
  bit          mfc_dead = 1'b0;

  // Reference model state.
  logic [DW-1:0] exp_f_rd = '0;
  logic [DW-1:0] exp_d_rd = '0;
  bit            last_tie = 1'b1;

  // Monitor counters.
  int   rises = 0;
  int   hi_run = 0;
  int   last_hi = 0;
  int   ack_seen = 0;
  int   both_ack = 0;
  logic en_q = 1'b0;

  // Memory device: MFC rises a few cycles after Enable, falls after
  // Enable drops; mfc_dead models a Memory that never answers.
  initial begin
    forever begin
      wait (mem_enable === 1'b1);
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #3;
      if (mem_enable === 1'b1 && !mfc_dead) begin
        if (mem_rw === 1'b1) mem_rdata = dev[mem_addr];
        else dev[mem_addr] = mem_wdata;
        mem_mfc = 1'b1;
      end
      wait (mem_enable === 1'b0);
      #2 mem_mfc = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mem_enable === 1'b1 && en_q !== 1'b1) rises++;
    if (mem_enable === 1'b1) hi_run++;
    else begin
      if (hi_run > 0) last_hi = hi_run;
      hi_run = 0;
    end
    en_q = mem_enable;
    if (f_ack === 1'b1 || d_ack === 1'b1) ack_seen++;
    if (f_ack === 1'b1 && d_ack === 1'b1) both_ack++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input int budget, output int who,
                          output logic e);
    who = -1;
    e = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (f_ack === 1'b1 || d_ack === 1'b1) begin
        who = (f_ack === 1'b1) ? 0 : 1;
        e = err;
        return;
      end
    end
  endtask

  // One request round; order and data come from the reference model.
  task automatic run_pair(input bit rf, input bit rd,
                          input logic [AW-1:0] fa, input bit drw,
                          input logic [AW-1:0] da,
                          input logic [DW-1:0] dw);
    int   order[$];
    int   who;
    int   w;
    logic e;
    if (rf && rd) begin
      w = last_tie ? 0 : 1;
      last_tie = (w == 1);
      order.push_back(w);
      order.push_back(1 - w);
    end else if (rf) begin
      order.push_back(0);
    end else if (rd) begin
      order.push_back(1);
    end
    f_addr = fa;
    d_addr = da;
    d_rw = drw;
    d_wdata = dw;
    f_req = rf;
    d_req = rd;
    foreach (order[k]) begin
      rises = 0;
      wait_ack(60, who, e);
      chk("ack_who", who, order[k]);
      if (who < 0) begin
        f_req = 1'b0;
        d_req = 1'b0;
        break;
      end
      if (order[k] == 0) exp_f_rd = ref_mem[fa];
      else if (drw) exp_d_rd = ref_mem[da];
      else ref_mem[da] = dw;
      if (who == 0) f_req = 1'b0;
      else d_req = 1'b0;
      chk("err", 32'(e), 0);
      chk("f_rdata", 32'(f_rdata), 32'(exp_f_rd));
      chk("d_rdata", 32'(d_rdata), 32'(exp_d_rd));
      chk("enable_periods", rises, 1);
    end
  endtask

  int   who;
  int   w;
  int   mode;
  int   snap;
  int   gap;
  logic e;

  initial begin
    dev[16'h0000] = 16'hB055;
    dev[16'h0002] = 16'h0042;
    dev[16'h0003] = 16'hA0C1;
    dev[16'h0021] = 16'h1234;
    ref_mem = dev;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_enable", 32'(mem_enable), 0);
    chk("rst_acks", 32'({f_ack, d_ack, err}), 0);
    chk("rst_bus", 32'({mem_rw, mem_addr}), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    chk("rst_rdata", 32'({f_rdata, d_rdata}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    run_pair(1, 0, 16'h0000, 1, 16'h0000, 16'h0000);
    chk("tp1_f_rdata", 32'(f_rdata), 32'h0000B055);

    run_pair(1, 1, 16'h0003, 1, 16'h0002, 16'h0000);
    chk("tp2_f_rdata", 32'(f_rdata), 32'h0000A0C1);
    chk("tp2_d_rdata", 32'(d_rdata), 32'h00000042);

    run_pair(1, 1, 16'h0000, 1, 16'h0003, 16'h0000);

    run_pair(0, 1, 16'h0000, 0, 16'h0020, 16'h1234);
    run_pair(0, 1, 16'h0000, 1, 16'h0021, 16'h0000);
    chk("tp3_d_rdata", 32'(d_rdata), 32'h00001234);
    run_pair(0, 1, 16'h0000, 1, 16'h0020, 16'h0000);
    chk("tp3_wr_back", 32'(d_rdata), 32'h00001234);

    // Both requests held: grants must alternate.
    f_addr = 16'h0003;
    d_addr = 16'h0002;
    d_rw = 1'b1;
    f_req = 1'b1;
    d_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      w = last_tie ? 0 : 1;
      last_tie = (w == 1);
      rises = 0;
      wait_ack(60, who, e);
      chk("rr_who", who, w);
      if (w == 0) exp_f_rd = ref_mem[16'h0003];
      else exp_d_rd = ref_mem[16'h0002];
      chk("rr_rdata", 32'({f_rdata, d_rdata}),
          32'({exp_f_rd, exp_d_rd}));
      chk("rr_periods", rises, 1);
      if (who < 0) break;
    end
    f_req = 1'b0;
    d_req = 1'b0;

    // Memory never answers: timeout with err.
    mfc_dead = 1'b1;
    rises = 0;
    f_addr = 16'h0002;
    f_req = 1'b1;
    wait_ack(60, who, e);
    f_req = 1'b0;
    chk("to_who", who, 0);
    chk("to_err", 32'(e), 1);
    chk("to_enable_len", last_hi, TO);
    chk("to_f_rdata", 32'(f_rdata), 32'(exp_f_rd));
    chk("to_periods", rises, 1);
    mfc_dead = 1'b0;

    // Reset in the middle of WAIT_MFC.
    mfc_dead = 1'b1;
    f_addr = 16'h0003;
    f_req = 1'b1;
    gap = 0;
    while (mem_enable !== 1'b1 && gap < 20) begin
      @(negedge clk);
      #1;
      gap++;
    end
    chk("mr_enable_seen", 32'(mem_enable), 1);
    @(negedge clk);
    @(negedge clk);
    snap = ack_seen;
    #2 rst_n = 1'b0;
    #1;
    chk("mr_enable_drop", 32'(mem_enable), 0);
    chk("mr_outputs", 32'({f_ack, d_ack, err}), 0);
    chk("mr_rdata", 32'({f_rdata, d_rdata}), 0);
    f_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("mr_no_ack", ack_seen, snap);
    mfc_dead = 1'b0;
    rst_n = 1'b1;
    last_tie = 1'b1;
    exp_f_rd = '0;
    exp_d_rd = '0;
    @(negedge clk);
    #1;
    run_pair(1, 0, 16'h0000, 1, 16'h0000, 16'h0000);
    chk("mr_f_rdata", 32'(f_rdata), 32'h0000B055);

    // Randomized rounds against the reference model.
    for (int it = 0; it < 16; it++) begin
      mode = $urandom_range(0, 2);
      run_pair(mode != 1, mode != 0, AW'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
               DW'($urandom));
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(negedge clk);
        #1;
      end
    end

    chk("never_both_acks", both_ack, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-ported Memory block.
- Shares Memory between an instruction-fetch requester (port F) and a data load/store requester (port D).
- Drives the Memory Enable/RW/Address/Data_in handshake and waits for MFC to rise and then fall.
- Returns read data and a one-cycle acknowledge to the winning requester, with a timeout if MFC never arrives.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- TIMEOUT, 32, maximum cycles in WAIT_MFC before the access is aborted (≥2).

Ports:
- clk  in  1  system clock, also drives Memory.
- rst_n  in  1  asynchronous active-low reset.
- f_req  in  1  fetch request (read only); held until f_ack.
- f_addr  in  AW  fetch address.
- f_ack  out  1  one-cycle pulse: fetch done, f_rdata valid.
- f_rdata  out  DW  fetch read data, held until next f_ack.
- d_req  in  1  data request; held until d_ack.
- d_rw  in  1  1 = read, 0 = write (Memory RW polarity).
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_ack  out  1  one-cycle pulse: data access done.
- d_rdata  out  DW  data read data, held until next d_ack.
- err  out  1  one-cycle pulse with the ack when the access timed out.
- mem_enable  out  1  to Memory Enable.
- mem_rw  out  1  to Memory RW.
- mem_addr  out  AW  to Memory Address.
- mem_wdata  out  DW  to Memory Data_in.
- mem_rdata  in  DW  from Memory Data_out.
- mem_mfc  in  1  from Memory MFC; asynchronous to clk edges.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0. State = IDLE, last_grant = D (so F wins the first tie). Counter cleared.
  - Reset mid-access drops mem_enable at once. No ack is issued.
- mem_mfc synchronisation: through a 2-flop synchroniser → mfc_s. Only mfc_s is used internally.
- Outputs are registered; mem_* are driven only from state/latched registers.
- State machine:
  - IDLE:
    - If f_req or d_req, grant one requester. Latch addr, rw (F forces rw=1) and wdata.
    - Next state ISSUE.
    - Arbitration: a single requester wins. On a tie the requester not in last_grant wins, then last_grant is updated (round robin).
  - ISSUE:
    - mem_enable=1, mem_rw/addr/wdata = latched values. Counter cleared.
    - Next state WAIT_MFC.
  - WAIT_MFC:
    - Hold mem_enable and the bus stable. Counter increments.
    - If mfc_s=1: capture mem_rdata into the granted rdata register (reads only), clear mem_enable, go to RELEASE.
    - If counter reaches TIMEOUT-1 with no mfc_s: clear mem_enable, set the timeout flag, go to RELEASE.
  - RELEASE:
    - mem_enable=0. Wait until mfc_s=0 (Memory clears MFC on Enable falling), then go to DONE.
    - Timeout in this state uses the same counter, restarted at RELEASE entry: on TIMEOUT go to DONE with the flag set.
  - DONE:
    - Pulse the granted ack for 1 cycle, plus err if the flag is set. Clear the flag.
    - Next state IDLE. No new grant in this cycle.
- Minimum turnaround, req to ack: 1 (IDLE) + 1 (ISSUE) + MFC latency + synchroniser 2 + release + 1 cycles.
- Back-to-back requests are never overlapped; mem_enable is always low for ≥1 cycle between accesses.
- Requests are sampled only in IDLE. A deasserted req mid-access does not cancel it; the ack is still pulsed.
- A write does not modify the rdata registers. On err, rdata is not updated.
- f_ack and d_ack are never high in the same cycle.

Test Plan:
- Reset, then f_req with f_addr=0x0000 → one mem_enable high period, f_ack pulse, f_rdata=0xB055, err=0.
- f_req with addr 3 and d_req with d_rw=1, d_addr=2, raised in the same cycle → F served first (f_rdata=0xA0C1), then D (d_rdata=0x0042). Check last_grant alternation on the next tie.
- d_req write: d_rw=0, d_addr=0x0020, d_wdata=0x1234. Then d_req read at d_addr=0x0021 → d_ack, d_rdata=0x1234. f_rdata is unchanged.
- Both requests held continuously for 6 accesses → grants alternate F,D,F,D,F,D. mem_enable low ≥1 cycle between each.
- mem_mfc tied 0 → mem_enable drops after TIMEOUT cycles, the requester's ack and err pulse together, rdata unchanged.
- rst_n asserted while in WAIT_MFC → mem_enable=0 immediately, no ack. After release, a new f_req completes normally.
